// File: rtl/fpall_pkg.sv
// Shared types and constants for the SIMD FP32 / dual-16-bit add/mul path.
// Provides opcode/format enums, operand classes, qNaN patterns and a lane classifier.
package fpall_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } fp_op_e;

    // FP16 here means two lanes of 1/8/7 (sign/exponent/fraction) bits.
    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
    localparam logic [15:0] FP16L_QNAN = 16'h7FC0;

    // Denormals share exponent 0 with zero and are flushed to zero.
    function automatic fp_class_e fp_classify_lane(
        input logic [7:0] exp,
        input logic       frac_nz
    );
        if (exp == 8'h00) begin
            return CLS_ZERO;
        end else if (exp == 8'hFF) begin
            return frac_nz ? CLS_NAN : CLS_INF;
        end
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_special_case.sv
// Combinational special-operand resolver: classifies X/Y per lane and yields per-lane override.
// Ports: opcode, fmt, x, y in; ovr_hi/ovr_lo flags and ovr_val (FP32 sets both flags together) out.
module fp_special_case
    import fpall_pkg::*;
(
    input  fp_op_e      opcode,
    input  fp_fmt_e     fmt,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        ovr_hi,
    output logic        ovr_lo,
    output logic [31:0] ovr_val
);

    typedef enum logic [2:0] {
        K_NONE,
        K_QNAN,
        K_X,
        K_Y,
        K_INF,
        K_ZERO
    } kind_e;

    typedef struct packed {
        kind_e kind;
        logic  sign;
    } fix_t;

    // Width-independent decision; the caller builds the actual bit pattern.
    function automatic fix_t resolve(
        input fp_op_e    op,
        input fp_class_e cx,
        input fp_class_e cy,
        input logic      sx,
        input logic      sy
    );
        fix_t f;
        f.kind = K_NONE;
        f.sign = 1'b0;
        if (cx == CLS_NAN || cy == CLS_NAN) begin
            f.kind = K_QNAN;
        end else if (op == OP_ADD) begin
            if (cx == CLS_INF && cy == CLS_INF) begin
                f.kind = (sx != sy) ? K_QNAN : K_X;
            end else if (cx == CLS_INF) begin
                f.kind = K_X;
            end else if (cy == CLS_INF) begin
                f.kind = K_Y;
            end else if (cx == CLS_ZERO && cy == CLS_ZERO) begin
                f.kind = K_ZERO;
                f.sign = sx & sy;
            end else if (cx == CLS_ZERO) begin
                f.kind = K_Y;
            end else if (cy == CLS_ZERO) begin
                f.kind = K_X;
            end
        end else begin
            f.sign = sx ^ sy;
            if ((cx == CLS_INF && cy == CLS_ZERO) ||
                (cx == CLS_ZERO && cy == CLS_INF)) begin
                f.kind = K_QNAN;
            end else if (cx == CLS_INF || cy == CLS_INF) begin
                f.kind = K_INF;
            end else if (cx == CLS_ZERO || cy == CLS_ZERO) begin
                f.kind = K_ZERO;
            end
        end
        return f;
    endfunction

    fix_t w_fix;
    fix_t h_fix;
    fix_t l_fix;
    logic [31:0] w_val;
    logic [15:0] h_val;
    logic [15:0] l_val;

    always_comb begin
        w_fix = resolve(opcode,
                        fp_classify_lane(x[30:23], |x[22:0]),
                        fp_classify_lane(y[30:23], |y[22:0]),
                        x[31], y[31]);
        h_fix = resolve(opcode,
                        fp_classify_lane(x[30:23], |x[22:16]),
                        fp_classify_lane(y[30:23], |y[22:16]),
                        x[31], y[31]);
        l_fix = resolve(opcode,
                        fp_classify_lane(x[14:7], |x[6:0]),
                        fp_classify_lane(y[14:7], |y[6:0]),
                        x[15], y[15]);

        unique case (w_fix.kind)
            K_QNAN:  w_val = FP32_QNAN;
            K_X:     w_val = x;
            K_Y:     w_val = y;
            K_INF:   w_val = {w_fix.sign, 8'hFF, 23'h0};
            K_ZERO:  w_val = {w_fix.sign, 31'h0};
            default: w_val = 32'h0;
        endcase

        unique case (h_fix.kind)
            K_QNAN:  h_val = FP16L_QNAN;
            K_X:     h_val = x[31:16];
            K_Y:     h_val = y[31:16];
            K_INF:   h_val = {h_fix.sign, 8'hFF, 7'h0};
            K_ZERO:  h_val = {h_fix.sign, 15'h0};
            default: h_val = 16'h0;
        endcase

        unique case (l_fix.kind)
            K_QNAN:  l_val = FP16L_QNAN;
            K_X:     l_val = x[15:0];
            K_Y:     l_val = y[15:0];
            K_INF:   l_val = {l_fix.sign, 8'hFF, 7'h0};
            K_ZERO:  l_val = {l_fix.sign, 15'h0};
            default: l_val = 16'h0;
        endcase

        if (fmt == FP32) begin
            ovr_hi  = (w_fix.kind != K_NONE);
            ovr_lo  = (w_fix.kind != K_NONE);
            ovr_val = w_val;
        end else begin
            ovr_hi  = (h_fix.kind != K_NONE);
            ovr_lo  = (l_fix.kind != K_NONE);
            ovr_val = {h_val, l_val};
        end
    end

endmodule

// File: rtl/fp_op_sequencer.sv
// Valid/ready front-end holding core operands stable for CORE_CYCLES, then queuing results in order.
// Ports: clk, rst (async high); req_* in / req_ready out; core_* out, core_r in;
// rsp_valid/rsp_r/rsp_tag/rsp_fmt out, rsp_ready in. Macro FP_SPECIAL_EN adds special-operand override.
module fp_op_sequencer
    import fpall_pkg::*;
#(
    parameter int unsigned CORE_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  fp_op_e           req_opcode,
    input  fp_fmt_e          req_fmt,
    input  logic [31:0]      req_x,
    input  logic [31:0]      req_y,
    input  logic [TAG_W-1:0] req_tag,
    output fp_op_e           core_opcode,
    output fp_fmt_e          core_fmt,
    output logic [31:0]      core_x,
    output logic [31:0]      core_y,
    input  logic [31:0]      core_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_r,
    output logic [TAG_W-1:0] rsp_tag,
    output fp_fmt_e          rsp_fmt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       cnt;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      cap_r;

    logic [31:0]      r_mem   [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
    fp_fmt_e          fmt_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = !rst && (count < DEPTH_C);
                accept    = req_valid && req_ready;
                if (accept) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == 4'd0) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 4'd0;
            tag_q       <= '0;
            core_opcode <= OP_ADD;
            core_fmt    <= FP32;
            core_x      <= 32'h0;
            core_y      <= 32'h0;
        end else if (accept) begin
            cnt         <= 4'(CORE_CYCLES - 1);
            tag_q       <= req_tag;
            core_opcode <= req_opcode;
            core_fmt    <= req_fmt;
            core_x      <= req_x;
            core_y      <= req_y;
        end else if (state_q == S_EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

`ifdef FP_SPECIAL_EN
    logic        ovr_hi;
    logic        ovr_lo;
    logic [31:0] ovr_val;
    logic        ovr_hi_q;
    logic        ovr_lo_q;
    logic [31:0] ovr_val_q;

    // Classified from the request so the decision is ready before capture.
    fp_special_case u_special (
        .opcode  (req_opcode),
        .fmt     (req_fmt),
        .x       (req_x),
        .y       (req_y),
        .ovr_hi  (ovr_hi),
        .ovr_lo  (ovr_lo),
        .ovr_val (ovr_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_hi_q  <= 1'b0;
            ovr_lo_q  <= 1'b0;
            ovr_val_q <= 32'h0;
        end else if (accept) begin
            ovr_hi_q  <= ovr_hi;
            ovr_lo_q  <= ovr_lo;
            ovr_val_q <= ovr_val;
        end
    end

    assign cap_r = {ovr_hi_q ? ovr_val_q[31:16] : core_r[31:16],
                    ovr_lo_q ? ovr_val_q[15:0]  : core_r[15:0]};
`else
    assign cap_r = core_r;
`endif

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_r     = r_mem[rd_ptr];
    assign rsp_tag   = tag_mem[rd_ptr];
    assign rsp_fmt   = fmt_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[wr_ptr]   <= cap_r;
            tag_mem[wr_ptr] <= tag_q;
            fmt_mem[wr_ptr] <= core_fmt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Self-checking bench for fp_op_sequencer: vector table, corner sequences and random traffic.
// A transaction-level model (queue of pending responses) predicts every observable output.
module tb_fp_op_sequencer;
    import fpall_pkg::*;

    localparam int CC    = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    fp_op_e      req_opcode;
    fp_fmt_e     req_fmt;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_tag;
    fp_op_e      core_opcode;
    fp_fmt_e     core_fmt;
    logic [31:0] core_x;
    logic [31:0] core_y;
    logic [31:0] core_r;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_tag;
    fp_fmt_e     rsp_fmt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_op_sequencer #(.CORE_CYCLES(CC), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_fmt(req_fmt),
        .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
        .core_opcode(core_opcode), .core_fmt(core_fmt),
        .core_x(core_x), .core_y(core_y), .core_r(core_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_tag(rsp_tag), .rsp_fmt(rsp_fmt)
    );

    // Stand-in for the combinational core: true results for known vectors, a hash otherwise.
    function automatic logic [31:0] core_model(input fp_op_e op, input fp_fmt_e f,
                                               input logic [31:0] x, input logic [31:0] y);
        if (op == OP_ADD && f == FP32 && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        if (op == OP_MUL && f == FP16 && x == 32'h40004040 && y == 32'h3F804000) return 32'h400040C0;
        if (op == OP_MUL && f == FP32 && x == 32'h40000000 && y == 32'h40400000) return 32'h40C00000;
        if (op == OP_ADD && f == FP16 && x == 32'h3F804000 && y == 32'h3F804000) return 32'h40004080;
        if (op == OP_ADD && f == FP16 && x == 32'h7F803F80 && y == 32'hFF803F80) return 32'h55554000;
        if (op == OP_MUL) return (x ^ {y[15:0], y[31:16]}) + 32'h9E3779B9;
        return x + y + ((f == FP16) ? 32'h1 : 32'h0);
    endfunction

    assign core_r = core_model(core_opcode, core_fmt, core_x, core_y);

    typedef struct {
        logic [31:0] r;
        logic [3:0]  tag;
        fp_fmt_e     fmt;
    } rsp_t;

    rsp_t        mq[$];
    rsp_t        pend;
    bit          inflight;
    int          remaining;
    bit          acc_flag;
    bit          model_on;
    logic [31:0] mx;
    logic [31:0] my;
    fp_op_e      mop;
    fp_fmt_e     mfmt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now driven.
    task automatic model_next();
        bit p_pop;
        bit p_push;
        bit p_acc;
        acc_flag = 0;
        if (rst) begin
            mq.delete();
            inflight = 0;
            mx = 32'h0;
            my = 32'h0;
            mop = OP_ADD;
            mfmt = FP32;
            return;
        end
        p_pop  = (mq.size() != 0) && rsp_ready;
        p_push = inflight && (remaining == 1);
        p_acc  = !inflight && (mq.size() < DEPTH) && req_valid;
        if (p_pop) void'(mq.pop_front());
        if (p_push) begin
            mq.push_back(pend);
            inflight = 0;
        end else if (inflight) begin
            remaining--;
        end
        if (p_acc) begin
            inflight = 1;
            remaining = CC;
            pend.r = core_model(req_opcode, req_fmt, req_x, req_y);
            pend.tag = req_tag;
            pend.fmt = req_fmt;
            mx = req_x;
            my = req_y;
            mop = req_opcode;
            mfmt = req_fmt;
            acc_flag = 1;
        end
    endtask

    task automatic compare_all();
        chk("req_ready", req_ready, !rst && !inflight && (mq.size() < DEPTH));
        chk("rsp_valid", rsp_valid, mq.size() != 0);
        chk("core_x", core_x, mx);
        chk("core_y", core_y, my);
        chk("core_opcode", core_opcode, mop);
        chk("core_fmt", core_fmt, mfmt);
        if (mq.size() != 0) begin
            chk("rsp_r", rsp_r, mq[0].r);
            chk("rsp_tag", rsp_tag, mq[0].tag);
            chk("rsp_fmt", rsp_fmt, mq[0].fmt);
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
        if (model_on) compare_all();
    endtask

    task automatic set_req(input fp_op_e op, input fp_fmt_e f, input logic [31:0] x,
                           input logic [31:0] y, input logic [3:0] tag);
        req_opcode = op;
        req_fmt = f;
        req_x = x;
        req_y = y;
        req_tag = tag;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!req_ready && w < 40) begin
            tick();
            w++;
        end
        if (w >= 40) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("rsp_valid_timeout", 0, 1);
    endtask

    task automatic issue(input fp_op_e op, input fp_fmt_e f, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] tag);
        set_req(op, f, x, y, tag);
        req_valid = 1'b1;
        wait_ready();
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_capture(input fp_op_e op, input fp_fmt_e f, input logic [31:0] x,
                               input logic [31:0] y, output logic [31:0] at_cap,
                               output logic [31:0] got);
        rsp_ready = 1'b0;
        issue(op, f, x, y, 4'd3);
        repeat (CC - 1) tick();
        at_cap = core_r;
        tick();
        chk("cap_valid", rsp_valid, 1);
        got = rsp_r;
        rsp_ready = 1'b1;
        tick();
    endtask

    typedef struct {
        fp_op_e      op;
        fp_fmt_e     fmt;
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  tag;
        logic [31:0] exp_r;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int nt;
        logic [3:0] got_tags[$];
        logic [31:0] at_cap;
        logic [31:0] got;

        vecs[0] = '{OP_ADD, FP32, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000};
        vecs[1] = '{OP_MUL, FP16, 32'h40004040, 32'h3F804000, 4'd6, 32'h400040C0};
        vecs[2] = '{OP_MUL, FP32, 32'h40000000, 32'h40400000, 4'd7, 32'h40C00000};
        vecs[3] = '{OP_ADD, FP16, 32'h3F804000, 32'h3F804000, 4'd8, 32'h40004080};

        model_on = 1;
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        set_req(OP_MUL, FP16, 32'h0, 32'h0, 4'd0);

        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_core_x", core_x, 32'h0);
        chk("rst_core_y", core_y, 32'h0);
        chk("rst_core_opcode", core_opcode, OP_ADD);
        chk("rst_core_fmt", core_fmt, FP32);
        tick();
        rst = 1'b0;
        tick();

        // Single operations with full latency check.
        for (int i = 0; i < 4; i++) begin
            rsp_ready = 1'b1;
            issue(vecs[i].op, vecs[i].fmt, vecs[i].x, vecs[i].y, vecs[i].tag);
            wait_rsp(n);
            chk("vec_latency", n, CC);
            chk("vec_rsp_r", rsp_r, vecs[i].exp_r);
            chk("vec_rsp_tag", rsp_tag, vecs[i].tag);
            chk("vec_rsp_fmt", rsp_fmt, vecs[i].fmt);
            tick();
        end

        // Backpressure: only FIFO_DEPTH ops accepted, order preserved.
        rsp_ready = 1'b0;
        nt = 1;
        for (int c = 0; c < 14; c++) begin
            set_req(OP_ADD, FP32, 32'h3F000000 + nt, 32'h3E000000, 4'(nt));
            req_valid = (nt <= 3);
            tick();
            if (acc_flag) nt++;
        end
        chk("bp_accepted", nt, 3);
        chk("bp_ready_stall", req_ready, 0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got_tags.size() < 3; c++) begin
            if (rsp_valid && rsp_ready) got_tags.push_back(rsp_tag);
            set_req(OP_ADD, FP32, 32'h3F000000 + nt, 32'h3E000000, 4'(nt));
            req_valid = (nt <= 3);
            tick();
            if (acc_flag) nt++;
        end
        req_valid = 1'b0;
        chk("bp_rsp_count", got_tags.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (got_tags.size() > i) chk("bp_rsp_order", got_tags[i], i + 1);
        end
        repeat (3) tick();

        // Push and pop on the same edge with one entry already held.
        rsp_ready = 1'b0;
        issue(OP_MUL, FP32, 32'h40100000, 32'h3FC00000, 4'd9);
        wait_rsp(n);
        set_req(OP_ADD, FP16, 32'h40404040, 32'h3F803F80, 4'd10);
        req_valid = 1'b1;
        tick();
        chk("pp_accept", acc_flag, 1);
        req_valid = 1'b0;
        repeat (CC - 1) tick();
        chk("pp_head_old", rsp_tag, 4'd9);
        rsp_ready = 1'b1;
        tick();
        chk("pp_still_valid", rsp_valid, 1);
        chk("pp_head_new", rsp_tag, 4'd10);
        tick();
        chk("pp_drained", rsp_valid, 0);

        // Reset during EXEC with one response held.
        rsp_ready = 1'b0;
        issue(OP_ADD, FP32, 32'h41000000, 32'h40800000, 4'd11);
        wait_rsp(n);
        issue(OP_MUL, FP16, 32'h41004100, 32'h40404040, 4'd12);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);
        rsp_ready = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_no_stale", rsp_valid, 0);
        end

        // Special operands: overridden with the feature, raw core result without it.
        model_on = 0;
        run_capture(OP_MUL, FP32, 32'h7F800000, 32'h00000000, at_cap, got);
`ifdef FP_SPECIAL_EN
        chk("spec_inf_x_zero", got, 32'h7FC00000);
`else
        chk("raw_inf_x_zero", got, at_cap);
`endif
        run_capture(OP_ADD, FP16, 32'h7F803F80, 32'hFF803F80, at_cap, got);
`ifdef FP_SPECIAL_EN
        chk("spec_hi_qnan", got[31:16], 16'h7FC0);
        chk("spec_lo_core", got[15:0], 16'h4000);
`else
        chk("raw_fp16_add", got, at_cap);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        model_on = 1;

        // Random traffic against the model; exponents kept normal so no lane is special.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] rx;
            logic [31:0] ry;
            rx = $urandom;
            ry = $urandom;
            rx[30] = 1'b0; rx[29] = 1'b1; rx[14] = 1'b0; rx[13] = 1'b1;
            ry[30] = 1'b0; ry[29] = 1'b1; ry[14] = 1'b0; ry[13] = 1'b1;
            set_req(fp_op_e'($urandom_range(0, 1)), fp_fmt_e'($urandom_range(0, 1)),
                    rx, ry, 4'($urandom_range(0, 15)));
            req_valid = ($urandom_range(0, 9) < 6);
            rsp_ready = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("final_drained", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
